// File: rtl/latency_result_fifo.sv
// latency_result_fifo
// Multi-channel result buffer. NUM_CH producers are round-robin arbitrated
// into a DEPTH-entry FIFO. On write, the embedded issue timestamp field
// [TS_LSB +: TS_W] is replaced by (counter_in - ts) mod 2^TS_W. Words drain
// in order through a first-word-fall-through head register.
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   clear                  synchronous flush (pointers, count, out_valid, rr)
//   in_data/in_valid       per-channel producer words, channel c at [c*DATA_W +: DATA_W]
//   in_ready               one-hot grant (or zero); independent of out_ready
//   counter_in             free-running cycle counter, sampled at acceptance
//   out_data/out_valid     head word
//   out_ready              consumer accepts head
//   count, full            registered occupancy (head included), count == DEPTH
module latency_result_fifo #(
    parameter int DATA_W = 88,
    parameter int TS_LSB = 16,
    parameter int TS_W   = 64,
    parameter int DEPTH  = 20,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [TS_W-1:0]          counter_in,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         count,
    output logic                     full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [RR_W-1:0]     rr;
    logic [2*NUM_CH-1:0] req_rot;
    logic                gnt_any;
    logic [RR_W:0]       gnt_sum;
    logic [RR_W-1:0]     gnt_idx;
    logic [NUM_CH-1:0]   grant;
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W-1:0]   wr_data;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [DATA_W-1:0]   head;
    logic                head_valid;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_next;
    logic                full_q;

    logic push, pop, arr_empty, load_from_arr, load_from_in, write_arr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Rotate the requests so bit 0 is channel rr; the lowest set bit of the
    // rotated vector is the winner, then map its offset back to a channel.
    always_comb begin
        req_rot = {in_valid, in_valid} >> rr;
        gnt_any = 1'b0;
        gnt_sum = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_any = 1'b1;
                gnt_sum = (RR_W + 1)'(i);
            end
        end
        gnt_sum = gnt_sum + {1'b0, rr};
        if (gnt_sum >= (RR_W + 1)'(NUM_CH))
            gnt_sum = gnt_sum - (RR_W + 1)'(NUM_CH);
        gnt_idx = gnt_sum[RR_W-1:0];
        grant = '0;
        if (gnt_any && !full_q && !clear) begin
            for (int c = 0; c < NUM_CH; c++)
                if (RR_W'(c) == gnt_idx) grant[c] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (grant[c]) sel_data = sel_data | in_data[c*DATA_W +: DATA_W];
        wr_data = sel_data;
        wr_data[TS_LSB +: TS_W] = counter_in - sel_data[TS_LSB +: TS_W];
    end

    // Head register bypass: an incoming word goes straight to the head when
    // the head is empty, or when the head is leaving and nothing is queued.
    always_comb begin
        push          = |grant;
        pop           = head_valid & out_ready & ~clear;
        arr_empty     = (count_q == CNT_W'(head_valid));
        load_from_arr = pop & ~arr_empty;
        load_from_in  = push & (~head_valid | (pop & arr_empty));
        write_arr     = push & ~load_from_in;
        case ({push, pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head       <= '0;
            head_valid <= 1'b0;
            count_q    <= '0;
            full_q     <= 1'b0;
        end else if (clear) begin
            rr         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            count_q    <= '0;
            full_q     <= 1'b0;
        end else begin
            if (push) begin
                if (gnt_idx == RR_W'(NUM_CH - 1)) rr <= '0;
                else                               rr <= gnt_idx + 1'b1;
            end
            if (write_arr)     wr_ptr <= ptr_inc(wr_ptr);
            if (load_from_arr) rd_ptr <= ptr_inc(rd_ptr);
            if (load_from_in)       head <= wr_data;
            else if (load_from_arr) head <= mem[rd_ptr];
            if (load_from_in || load_from_arr) head_valid <= 1'b1;
            else if (pop)                      head_valid <= 1'b0;
            count_q <= count_next;
            full_q  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (write_arr) mem[wr_ptr] <= wr_data;
    end

    assign in_ready  = grant;
    assign out_data  = head;
    assign out_valid = head_valid;
    assign count     = count_q;
    assign full      = full_q;

endmodule

// File: tb/tb_latency_result_fifo.sv
module tb_latency_result_fifo;

    localparam int DATA_W = 88;
    localparam int TS_LSB = 16;
    localparam int TS_W   = 64;
    localparam int DEPTH  = 20;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                     clk;
    logic                     rstn;
    logic                     clear;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [TS_W-1:0]          counter_in;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W-1:0]         count;
    logic                     full;

    latency_result_fifo #(
        .DATA_W(DATA_W), .TS_LSB(TS_LSB), .TS_W(TS_W),
        .DEPTH(DEPTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .counter_in(counter_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    // Bench model state
    logic [DATA_W-1:0] sb_q [$];
    int                cnt_m;
    int                rr_m;
    int                n_push;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;

    typedef struct {
        int          ch;
        logic [63:0] ts;
        logic [63:0] ctr;
        logic [63:0] exp_field;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rword();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] latency_word(input logic [DATA_W-1:0] w,
                                                       input logic [TS_W-1:0] ctr);
        logic [DATA_W-1:0] r;
        r = w;
        r[TS_LSB +: TS_W] = ctr - w[TS_LSB +: TS_W];
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] model_ready(output int g);
        logic [NUM_CH-1:0] r;
        r = '0;
        g = -1;
        if (cnt_m != DEPTH && !clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                int c;
                c = (rr_m + i) % NUM_CH;
                if (g < 0 && in_valid[c]) begin
                    g = c;
                    r[c] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        cnt_m = 0;
        rr_m = 0;
        prev_stall = 1'b0;
    endtask

    // Called at a negedge after inputs are set; checks, updates the model,
    // and returns at the next negedge.
    task automatic step();
        logic [NUM_CH-1:0] exp_rdy;
        logic [DATA_W-1:0] exp_w;
        int g;
        logic push_m, pop_m;
        #1;
        exp_rdy = model_ready(g);
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("count", 128'(count), 128'(cnt_m));
        chk("full", 128'(full), 128'(cnt_m == DEPTH));
        chk("out_valid", 128'(out_valid), 128'(cnt_m != 0));
        if (prev_stall) chk("hold_data", 128'(out_data), 128'(prev_data));
        push_m = (g >= 0);
        pop_m  = (cnt_m != 0) && out_ready && !clear;
        if (pop_m) begin
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_underflow: got pop expected none");
            end else begin
                exp_w = sb_q.pop_front();
                chk("out_data", 128'(out_data), 128'(exp_w));
            end
        end
        prev_stall = (cnt_m != 0) && !out_ready && !clear;
        prev_data  = out_data;
        if (clear) begin
            sb_q.delete();
            cnt_m = 0;
            rr_m = 0;
        end else begin
            if (push_m) begin
                sb_q.push_back(latency_word(in_data[g*DATA_W +: DATA_W], counter_in));
                rr_m = (g + 1) % NUM_CH;
                n_push++;
            end
            cnt_m = cnt_m + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
        end
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = rword();
        counter_in = {$urandom(), $urandom()};
    endtask

    task automatic drain();
        in_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && cnt_m != 0; i++) step();
        chk("drain_empty", 128'(cnt_m), 128'(0));
        chk("drain_sb_empty", 128'(sb_q.size()), 128'(0));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        in_valid = '0;
        clear = 1'b0;
        #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] w, exp_word;
        logic [NUM_CH-1:0] alt_in  [8];
        logic [NUM_CH-1:0] alt_exp [8];

        vecs[0] = '{0, 64'd100, 64'd250, 64'd150};
        vecs[1] = '{1, 64'hFFFF_FFFF_FFFF_FFF6, 64'd5, 64'd15};
        vecs[2] = '{0, 64'd777, 64'd777, 64'd0};
        vecs[3] = '{1, 64'd1001, 64'd1000, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{1, 64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000};

        alt_in  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
        alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};

        n_push = 0;
        rstn = 1'b0; clear = 1'b0; in_valid = '0; out_ready = 1'b0;
        in_data = '0; counter_in = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Single-word latency rewrites, 1-cycle latency, other bits intact.
        for (int v = 0; v < 6; v++) begin
            w = rword();
            w[TS_LSB +: TS_W] = vecs[v].ts;
            in_data = '0;
            in_data[vecs[v].ch*DATA_W +: DATA_W] = w;
            in_valid = '0;
            in_valid[vecs[v].ch] = 1'b1;
            counter_in = vecs[v].ctr;
            out_ready = 1'b0;
            step();
            in_valid = '0;
            #1;
            exp_word = w;
            exp_word[TS_LSB +: TS_W] = vecs[v].exp_field;
            chk("vec_out_valid", 128'(out_valid), 128'(1));
            chk("vec_count", 128'(count), 128'(1));
            chk("vec_word", 128'(out_data), 128'(exp_word));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end

        // Fill to DEPTH with no drain, then stream through the pointer wrap.
        out_ready = 1'b0;
        in_valid = 2'b01;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rand_data();
            step();
        end
        #1;
        chk("fill_full", 128'(full), 128'(1));
        chk("fill_in_ready", 128'(in_ready), 128'(0));
        chk("fill_count", 128'(count), 128'(DEPTH));
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 5; i++) begin
            rand_data();
            step();
        end
        drain();

        // Mid-stream reset, then grant alternation from rr = 0.
        in_valid = 2'b11;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step();
        end
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            in_valid = alt_in[i];
            #1;
            chk("alt_grant", 128'(in_ready), 128'(alt_exp[i]));
            step();
        end
        drain();

        // Clear with seven words stored, including pushes/pops in the clear cycle.
        out_ready = 1'b0;
        in_valid = 2'b01;
        for (int i = 0; i < 20 && cnt_m < 7; i++) begin
            rand_data();
            step();
        end
        chk("pre_clear_count", 128'(count), 128'(7));
        clear = 1'b1;
        in_valid = 2'b11;
        out_ready = 1'b1;
        step();
        clear = 1'b0;
        in_valid = '0;
        #1;
        chk("clear_count", 128'(count), 128'(0));
        chk("clear_out_valid", 128'(out_valid), 128'(0));
        for (int i = 0; i < 12; i++) begin
            rand_data();
            in_valid = NUM_CH'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        // Random backpressure over 1000 words.
        n_push = 0;
        for (int i = 0; i < 6000 && n_push < 1000; i++) begin
            rand_data();
            in_valid = NUM_CH'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        chk("bp_words_pushed", 128'(n_push >= 1000), 128'(1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/latency_result_fifo.md
# latency_result_fifo

Multi-channel result buffer between the compute lanes and the host readout path. It accepts result words from NUM_CH producers through round-robin arbitration and replaces each word's embedded issue timestamp with the elapsed cycle count, computed against the free-running cycle counter. It stores up to DEPTH words and drains them in order over a ready/valid interface. It replaces the fixed 88-bit, single-channel, three-cycle-per-word output buffer with a one-word-per-cycle parametrised FIFO.

## Interface
- DATA_W, 88, result word width
- TS_LSB, 16, bit position of the timestamp field inside the word
- TS_W, 64, timestamp/counter width; TS_LSB+TS_W ≤ DATA_W
- DEPTH, 20, storage entries, any value ≥ 2 (not restricted to powers of two)
- NUM_CH, 2, producer channels, ≥ 1
- CNT_W, $clog2(DEPTH+1), occupancy width
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of all stored words
- in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- in_valid  in  NUM_CH  per-channel word valid
- in_ready  out  NUM_CH  per-channel accept (grant)
- counter_in  in  TS_W  free-running cycle counter
- out_data  out  DATA_W  head word
- out_valid  out  1  head word valid
- out_ready  in  1  consumer accepts the head word
- count  out  CNT_W  stored words, including the head register
- full  out  1  count == DEPTH

## Operation
- Latency rewrite on write: the stored word equals the input word, except bits [TS_LSB +: TS_W], which become (counter_in − ts) mod 2^TS_W, using an unsigned TS_W-bit subtract. Counter wrap is therefore handled implicitly. ts == counter_in gives 0. ts = counter_in+1 gives 2^TS_W−1.
- Arbiter:
  - A rotating priority pointer rr (0..NUM_CH−1), reset 0.
  - Each cycle, when not full and clear is low, grant the first requesting channel at or after rr, in cyclic order.
  - in_ready is one-hot, or all zero. It is a function of in_valid, rr, full and clear only; it never depends on out_ready.
  - After a grant to channel g, rr ← (g+1) mod NUM_CH. rr holds when there is no grant.
- Storage:
  - A circular register array with wr_ptr and rd_ptr, each wrapping from DEPTH−1 to 0.
  - A first-word-fall-through output register forms the head. count includes the head.
  - A push occurs on any in_valid & in_ready. A pop occurs on out_valid & out_ready.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, no push is granted in that cycle, even if a pop happens. full deasserts the following cycle.
- When empty, a push to an empty FIFO loads the head register directly. It does not pass through the array.
- clear:
  - Pointers, count and out_valid go to 0 and rr goes to 0 on the next edge.
  - Pushes and pops in the clear cycle are ignored.
- Reset is asynchronous. Every register is reset, the array contents are not reset, and state is lost mid-operation without drain.
- Output reset values: in_ready 0 (no requests pending), out_valid 0, out_data 0, count 0, full 0.

## Timing
- Throughput: one push and one pop per cycle.
- Latency: a word accepted at edge t into an empty FIFO shows out_valid=1 after edge t, i.e. 1 cycle.
- A word behind the head is presented the cycle after the preceding pop.
- Hold: while out_valid & !out_ready, out_data and out_valid hold stable.
- counter_in is sampled in the acceptance cycle.
- count and full are registered and update on the edge after a push or pop.

## Test plan
- Single word, channel 0, ts=100, counter_in=250. The word appears 1 cycle later with the ts field = 150, all other bits unchanged, and count=1.
- Wrap: TS_W=64, ts=2^64−10, counter_in=5. Stored field = 15.
- Fill to DEPTH=20 with out_ready=0:
  - full=1 and in_ready=0 from the next cycle.
  - Then hold out_ready=1 with continuous input: one word in and one out per cycle, order preserved across the pointer wrap at 19→0.
- Both channels valid every cycle, NUM_CH=2: grants alternate 0,1,0,1. A channel that drops valid is skipped without a stall.
- Backpressure: toggle out_ready randomly. out_data stays stable while stalled, and there is no loss or duplication over 1000 words, checked with a scoreboard.
- clear asserted with count=7, and rstn pulsed mid-stream: next cycle count=0, out_valid=0, and subsequent words restart correctly.
